// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// =============================================================================
// vi_mem_pkg : shared widths and types for the cache-to-memory arbiter | rev 1.0
// =============================================================================
package vi_mem_pkg;

    localparam int ADDR_W = 20;
    localparam int LINE_W = 128;
    localparam int OFFS_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } mem_state_t;

    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_DC = 1'b1
    } owner_t;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// =============================================================================
// mem_arbiter_if : icache/dcache request, memory and response buses | rev 1.0
// =============================================================================
interface mem_arbiter_if #(
    parameter int ADDR_W = vi_mem_pkg::ADDR_W,
    parameter int LINE_W = vi_mem_pkg::LINE_W
);
    logic              ic_rqst_i;
    logic [ADDR_W-1:0] ic_addr_i;
    logic              dc_rqst_i;
    logic              dc_we_i;
    logic [ADDR_W-1:0] dc_addr_i;
    logic [LINE_W-1:0] dc_wdata_i;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [LINE_W-1:0] mem_wdata_o;
    logic              mem_ack_i;
    logic [LINE_W-1:0] mem_rdata_i;
    logic              ic_data_ready_o;
    logic              dc_data_ready_o;
    logic [LINE_W-1:0] mem_data_o;
    logic [ADDR_W-1:0] mem_addr_resp_o;
    logic              busy_o;

    // Arbiter side
    modport slave (
        input  ic_rqst_i, ic_addr_i, dc_rqst_i, dc_we_i, dc_addr_i, dc_wdata_i,
               mem_ack_i, mem_rdata_i,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
               ic_data_ready_o, dc_data_ready_o, mem_data_o, mem_addr_resp_o, busy_o
    );

    // Caches and memory side
    modport master (
        output ic_rqst_i, ic_addr_i, dc_rqst_i, dc_we_i, dc_addr_i, dc_wdata_i,
               mem_ack_i, mem_rdata_i,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
               ic_data_ready_o, dc_data_ready_o, mem_data_o, mem_addr_resp_o, busy_o
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter_rr_arb.sv
`default_nettype none
// =============================================================================
// mem_rr_arb : two-input round-robin grant, ties go to the one not served last | rev 1.0
// =============================================================================
module mem_rr_arb
    import vi_mem_pkg::*;
(
    input  wire logic   clk_i,
    input  wire logic   rsn_i,
    input  wire logic   en_i,
    input  wire logic   ic_rqst_i,
    input  wire logic   dc_rqst_i,
    input  wire logic   upd_i,
    input  wire owner_t upd_owner_i,
    output logic        gnt_o,
    output owner_t      gnt_owner_o
);

    logic last_dc_q;
    logic last_dc_d;

    always_comb begin
        last_dc_d = last_dc_q;
        if (upd_i) begin
            last_dc_d = (upd_owner_i == OWN_DC);
        end
    end

    assign gnt_o       = en_i & (ic_rqst_i | dc_rqst_i);
    assign gnt_owner_o = (dc_rqst_i && (!ic_rqst_i || !last_dc_q)) ? OWN_DC : OWN_IC;

    always_ff @(posedge clk_i or posedge rsn_i) begin
        if (rsn_i) begin
            last_dc_q <= 1'b0;
        end else begin
            last_dc_q <= last_dc_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// =============================================================================
// mem_arbiter : icache/dcache refill and writeback arbiter onto main memory | rev 1.0
// =============================================================================
module mem_arbiter
    import vi_mem_pkg::*;
#(
    parameter int ADDR_W = vi_mem_pkg::ADDR_W,
    parameter int LINE_W = vi_mem_pkg::LINE_W,
    parameter int OFFS_W = vi_mem_pkg::OFFS_W
) (
    input  wire logic     clk_i,
    input  wire logic     rsn_i,
    mem_arbiter_if.slave  bus
);

    mem_state_t        state_q, state_d;
    owner_t            owner_q, owner_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              ic_rdy_q, ic_rdy_d;
    logic              dc_rdy_q, dc_rdy_d;
    logic [LINE_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] resp_addr_q, resp_addr_d;
    logic              busy_q, busy_d;

    logic              w_gnt;
    owner_t            w_gnt_owner;

    mem_rr_arb u_rr_arb (
        .clk_i       (clk_i),
        .rsn_i       (rsn_i),
        .en_i        (state_q == IDLE),
        .ic_rqst_i   (bus.ic_rqst_i),
        .dc_rqst_i   (bus.dc_rqst_i),
        .upd_i       (state_q == RESP),
        .upd_owner_i (owner_q),
        .gnt_o       (w_gnt),
        .gnt_owner_o (w_gnt_owner)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        req_d       = 1'b0;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        ic_rdy_d    = 1'b0;
        dc_rdy_d    = 1'b0;
        data_d      = data_q;
        resp_addr_d = resp_addr_q;
        case (state_q)
            IDLE: begin
                if (w_gnt) begin
                    state_d = ISSUE;
                    req_d   = 1'b1;
                    owner_d = w_gnt_owner;
                    if (w_gnt_owner == OWN_DC) begin
                        we_d    = bus.dc_we_i;
                        addr_d  = {bus.dc_addr_i[ADDR_W-1:OFFS_W], {OFFS_W{1'b0}}};
                        wdata_d = bus.dc_wdata_i;
                    end else begin
                        we_d    = 1'b0;
                        addr_d  = {bus.ic_addr_i[ADDR_W-1:OFFS_W], {OFFS_W{1'b0}}};
                        wdata_d = '0;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.mem_ack_i) begin
                    state_d     = RESP;
                    data_d      = we_q ? '0 : bus.mem_rdata_i;
                    resp_addr_d = addr_q;
                    ic_rdy_d    = (owner_q == OWN_IC);
                    dc_rdy_d    = (owner_q == OWN_DC);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or posedge rsn_i) begin
        if (rsn_i) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IC;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            ic_rdy_q    <= 1'b0;
            dc_rdy_q    <= 1'b0;
            data_q      <= '0;
            resp_addr_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ic_rdy_q    <= ic_rdy_d;
            dc_rdy_q    <= dc_rdy_d;
            data_q      <= data_d;
            resp_addr_q <= resp_addr_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.mem_req_o       = req_q;
    assign bus.mem_we_o        = we_q;
    assign bus.mem_addr_o      = addr_q;
    assign bus.mem_wdata_o     = wdata_q;
    assign bus.ic_data_ready_o = ic_rdy_q;
    assign bus.dc_data_ready_o = dc_rdy_q;
    assign bus.mem_data_o      = data_q;
    assign bus.mem_addr_resp_o = resp_addr_q;
    assign bus.busy_o          = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// =============================================================================
// tb_mem_arbiter : directed self-checking bench for mem_arbiter | rev 1.0
// =============================================================================
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    localparam logic [127:0] C_A5   = {16{8'hA5}};
    localparam logic [127:0] C_WB   = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;

    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk_i (clk),
        .rsn_i (rst),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".mem_req"},   128'(bus.mem_req_o),       128'd0);
        chk({tag, ".mem_we"},    128'(bus.mem_we_o),        128'd0);
        chk({tag, ".mem_addr"},  128'(bus.mem_addr_o),      128'd0);
        chk({tag, ".mem_wdata"}, bus.mem_wdata_o,           128'd0);
        chk({tag, ".ic_rdy"},    128'(bus.ic_data_ready_o), 128'd0);
        chk({tag, ".dc_rdy"},    128'(bus.dc_data_ready_o), 128'd0);
        chk({tag, ".mem_data"},  bus.mem_data_o,            128'd0);
        chk({tag, ".resp_addr"}, 128'(bus.mem_addr_resp_o), 128'd0);
        chk({tag, ".busy"},      128'(bus.busy_o),          128'd0);
    endtask

    initial begin
        bus.ic_rqst_i   = 1'b0;
        bus.ic_addr_i   = '0;
        bus.dc_rqst_i   = 1'b0;
        bus.dc_we_i     = 1'b0;
        bus.dc_addr_i   = '0;
        bus.dc_wdata_i  = '0;
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = '0;
        tick();
        tick();
        rst = 1'b0;
        chk_all_zero("reset");

        // icache refill, ack 3 cycles after the request pulse, address changes in WAIT
        bus.ic_rqst_i = 1'b1;
        bus.ic_addr_i = 20'h1234C;
        tick();
        chk("ic.req",    128'(bus.mem_req_o),  128'd1);
        chk("ic.addr",   128'(bus.mem_addr_o), 128'h12340);
        chk("ic.we",     128'(bus.mem_we_o),   128'd0);
        chk("ic.busy",   128'(bus.busy_o),     128'd1);
        tick();
        chk("ic.req_off", 128'(bus.mem_req_o), 128'd0);
        bus.ic_addr_i = 20'h55557;
        tick();
        chk("ic.addr_hold", 128'(bus.mem_addr_o), 128'h12340);
        tick();
        chk("ic.no_rdy_early", 128'(bus.ic_data_ready_o), 128'd0);
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = C_A5;
        tick();
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = '0;
        chk("ic.rdy",       128'(bus.ic_data_ready_o), 128'd1);
        chk("ic.dc_rdy",    128'(bus.dc_data_ready_o), 128'd0);
        chk("ic.data",      bus.mem_data_o,            C_A5);
        chk("ic.resp_addr", 128'(bus.mem_addr_resp_o), 128'h12340);
        chk("ic.addr_resp_hold", 128'(bus.mem_addr_o), 128'h12340);
        bus.ic_rqst_i = 1'b0;
        tick();
        chk("ic.rdy_pulse", 128'(bus.ic_data_ready_o), 128'd0);
        chk("ic.idle",      128'(bus.busy_o),          128'd0);

        // round robin with both requesters held active from reset: DC, IC, DC, IC
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.ic_addr_i = 20'h11117;
        bus.dc_addr_i = 20'h2222A;
        bus.dc_we_i   = 1'b0;
        bus.ic_rqst_i = 1'b1;
        bus.dc_rqst_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic exp_dc;
            exp_dc = ((i % 2) == 0);
            tick();
            chk("rr.req",  128'(bus.mem_req_o), 128'd1);
            chk("rr.addr", 128'(bus.mem_addr_o), exp_dc ? 128'h22220 : 128'h11110);
            tick();
            bus.mem_ack_i   = 1'b1;
            bus.mem_rdata_i = 128'(i + 1);
            tick();
            bus.mem_ack_i   = 1'b0;
            chk("rr.dc_rdy", 128'(bus.dc_data_ready_o), 128'(exp_dc));
            chk("rr.ic_rdy", 128'(bus.ic_data_ready_o), 128'(!exp_dc));
            chk("rr.data",   bus.mem_data_o,            128'(i + 1));
            tick();
        end
        bus.ic_rqst_i   = 1'b0;
        bus.dc_rqst_i   = 1'b0;
        bus.mem_rdata_i = '0;

        // spurious ack in IDLE
        bus.mem_ack_i = 1'b1;
        tick();
        bus.mem_ack_i = 1'b0;
        chk("sp_idle.busy", 128'(bus.busy_o),          128'd0);
        chk("sp_idle.rdy",  128'(bus.dc_data_ready_o | bus.ic_data_ready_o), 128'd0);
        chk("sp_idle.req",  128'(bus.mem_req_o),       128'd0);

        // dcache writeback with a spurious ack during ISSUE
        bus.dc_rqst_i  = 1'b1;
        bus.dc_we_i    = 1'b1;
        bus.dc_addr_i  = 20'h0F0F8;
        bus.dc_wdata_i = C_WB;
        tick();
        chk("wb.req",   128'(bus.mem_req_o),  128'd1);
        chk("wb.we",    128'(bus.mem_we_o),   128'd1);
        chk("wb.addr",  128'(bus.mem_addr_o), 128'h0F0F0);
        chk("wb.wdata", bus.mem_wdata_o,      C_WB);
        bus.mem_ack_i = 1'b1;
        tick();
        bus.mem_ack_i = 1'b0;
        chk("sp_issue.busy", 128'(bus.busy_o),          128'd1);
        chk("sp_issue.rdy",  128'(bus.dc_data_ready_o), 128'd0);
        chk("sp_issue.req",  128'(bus.mem_req_o),       128'd0);
        tick();
        chk("wb.wait_busy", 128'(bus.busy_o),          128'd1);
        chk("wb.wait_rdy",  128'(bus.dc_data_ready_o), 128'd0);
        chk("wb.we_hold",   128'(bus.mem_we_o),        128'd1);
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = C_A5;
        tick();
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = '0;
        chk("wb.dc_rdy",    128'(bus.dc_data_ready_o), 128'd1);
        chk("wb.ic_rdy",    128'(bus.ic_data_ready_o), 128'd0);
        chk("wb.data_zero", bus.mem_data_o,            128'd0);
        chk("wb.resp_addr", 128'(bus.mem_addr_resp_o), 128'h0F0F0);
        bus.dc_rqst_i = 1'b0;
        bus.dc_we_i   = 1'b0;
        tick();
        chk("wb.idle", 128'(bus.busy_o), 128'd0);

        // reset asserted mid-WAIT, then a late ack
        bus.ic_rqst_i = 1'b1;
        bus.ic_addr_i = 20'h0ABC4;
        tick();
        tick();
        chk("rw.busy_wait", 128'(bus.busy_o), 128'd1);
        rst = 1'b1;
        #1;
        chk("rw.async_busy", 128'(bus.busy_o),     128'd0);
        chk("rw.async_addr", 128'(bus.mem_addr_o), 128'd0);
        tick();
        rst = 1'b0;
        bus.ic_rqst_i   = 1'b0;
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = C_A5;
        tick();
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = '0;
        chk_all_zero("late_ack");
        tick();
        chk_all_zero("late_ack2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits directly below the core's instruction_cache and data cache refill paths (the unconnected memory ports of both caches).
- Arbitrates line-refill reads from the icache and refill/writeback requests from the dcache onto a single main-memory request/acknowledge interface.
- Returns the refill line on a shared response bus, with a one-cycle ready pulse to the winning requester.
- One transaction outstanding at a time.

Parameters:
- ADDR_W, 20, physical address width (matches the TLB physical output).
- LINE_W, 128, cache line width in bits.
- OFFS_W, 4, line-offset bits; these are forced to zero on the memory address.

Ports:
- clk_i  in  1  clock
- rsn_i  in  1  reset; asynchronous, active-high
- ic_rqst_i  in  1  icache refill request; level, held until ic_data_ready_o
- ic_addr_i  in  ADDR_W  icache miss address
- dc_rqst_i  in  1  dcache request; level, held until dc_data_ready_o
- dc_we_i  in  1  1 = writeback of dc_wdata_i, 0 = refill read
- dc_addr_i  in  ADDR_W  dcache address
- dc_wdata_i  in  LINE_W  writeback line
- mem_req_o  out  1  main-memory request
- mem_we_o  out  1  main-memory write
- mem_addr_o  out  ADDR_W  line-aligned address
- mem_wdata_o  out  LINE_W  write line
- mem_ack_i  in  1  memory completion pulse; carries read data
- mem_rdata_i  in  LINE_W  read line, valid with mem_ack_i
- ic_data_ready_o  out  1  one-cycle pulse, icache transaction done
- dc_data_ready_o  out  1  one-cycle pulse, dcache transaction done
- mem_data_o  out  LINE_W  response line, valid with either ready pulse
- mem_addr_resp_o  out  ADDR_W  line-aligned address of the response
- busy_o  out  1  FSM not IDLE

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP. A register `owner` holds IC or DC.
- IDLE:
  - Samples the requests.
  - If only one requester is active, that requester is granted.
  - If both are active, the requester not served last is granted (register `last_dc`). After reset `last_dc` = 0, so the dcache wins the first tie.
  - On grant: capture address with offset zeroed, we (0 for icache), and wdata into registers; go to ISSUE.
- ISSUE:
  - mem_req_o = 1 for exactly one cycle, with mem_we_o/mem_addr_o/mem_wdata_o driven from the captured registers.
  - Next state is WAIT.
- WAIT:
  - mem_req_o = 0; address, we and wdata outputs hold their values.
  - On mem_ack_i: capture mem_rdata_i (zeros for writes) into the response register; go to RESP.
  - No timeout.
- RESP:
  - Exactly one of ic_data_ready_o/dc_data_ready_o is 1, per `owner`. mem_data_o and mem_addr_resp_o are valid.
  - Update `last_dc`; go to IDLE.
- Latency:
  - Request sampled in IDLE at cycle T → mem_req_o at T+1.
  - mem_ack_i at cycle A → ready pulse at A+1.
  - Minimum round trip, with ack in the cycle after ISSUE: 4 cycles.
- The requester deasserts its rqst in the cycle after its ready pulse. IDLE does not re-grant on that cycle because the rqst is already low; caches drive rqst from registered state.
- mem_ack_i outside WAIT is ignored, with no state change.
- Request inputs changing while not in IDLE are ignored; only the captured values are used.
- Back-to-back requests: IDLE is always visited between transactions, giving one cycle of bubble minimum.
- Reset:
  - State IDLE, `last_dc` = 0.
  - All outputs 0: mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, both ready pulses, mem_data_o, mem_addr_resp_o, busy_o.
  - Captured registers are cleared.
  - Reset mid-WAIT abandons the transaction. A late mem_ack_i after reset is ignored, because the FSM is in IDLE.
- busy_o = (state != IDLE), registered from the state.

Decomposition:
- Package vi_mem_pkg holds:
  - constants ADDR_W, LINE_W, OFFS_W;
  - typedef mem_state_t {IDLE, ISSUE, WAIT, RESP};
  - typedef owner_t {OWN_IC, OWN_DC}.
- One sub-module is natural: mem_rr_arb. It is a 2-input round-robin grant with the `last_dc` register and a grant-enable input, instantiated once. The FSM and datapath registers stay in mem_arbiter.

Test Plan:
- Reset, then ic_rqst_i = 1, ic_addr_i = 0x1234C; memory acks 3 cycles after mem_req_o with rdata 0xA5..A5:
  - mem_req_o pulses once, mem_addr_o = 0x12340, mem_we_o = 0;
  - ic_data_ready_o pulses 1 cycle after ack, mem_data_o = 0xA5..A5, mem_addr_resp_o = 0x12340.
- Both requesters active from reset, each re-requesting immediately after service: grant order is DC, IC, DC, IC; no requester is served twice in a row.
- dc_rqst_i = 1, dc_we_i = 1, dc_addr_i = 0x0F0F8, dc_wdata_i = 0xDEAD..BEEF:
  - mem_we_o = 1, mem_addr_o = 0x0F0F0, mem_wdata_o = 0xDEAD..BEEF;
  - after ack, dc_data_ready_o pulses and mem_data_o = 0.
- Assert rsn_i during WAIT, release it, then pulse mem_ack_i: no ready pulse, busy_o = 0, all outputs 0.
- Spurious mem_ack_i in IDLE and in ISSUE: no state change, no ready pulse.
- ic_addr_i changes during WAIT: mem_addr_o and mem_addr_resp_o keep the originally captured address.
